// File: rtl/ring_router_demux.sv
// Ring router demux: steers worms from the ring to the local port or onward.
// Build macro RING_ROUTER_DEMUX_BCAST_EN enables broadcast copy to both outputs.
module ring_router_demux #(
  parameter logic [15:0] ID         = 16'h0000,
  parameter logic [15:0] BCAST_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_ring_data,
  input  logic        in_ring_first,
  input  logic        in_ring_last,
  input  logic        in_ring_valid,
  output logic        in_ring_ready,
  output logic [15:0] out_local_data,
  output logic        out_local_first,
  output logic        out_local_last,
  output logic        out_local_valid,
  input  logic        out_local_ready,
  output logic [15:0] out_ring_data,
  output logic        out_ring_first,
  output logic        out_ring_last,
  output logic        out_ring_valid,
  input  logic        out_ring_ready
);

`ifdef RING_ROUTER_DEMUX_BCAST_EN
  typedef enum logic [1:0] {
    IDLE, WORM_LOCAL, WORM_RING, WORM_BCAST
  } state_t;
  localparam state_t BST = WORM_BCAST;
  logic hit_bcast;
  assign hit_bcast = (in_ring_data == BCAST_ADDR);
`else
  typedef enum logic [1:0] {
    IDLE, WORM_LOCAL, WORM_RING
  } state_t;
  localparam state_t BST = IDLE;
  logic hit_bcast;
  assign hit_bcast = 1'b0 && (in_ring_data == BCAST_ADDR);
`endif

  state_t state, state_n;
  logic   alive;
  logic   to_loc, to_ring;
  logic   loc_acc, ring_acc;
  logic   fire;

  assign loc_acc  = !out_local_valid || out_local_ready;
  assign ring_acc = !out_ring_valid || out_ring_ready;
  assign fire     = in_ring_valid && in_ring_ready;

  // Hold off input acceptance until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  // Worm state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Route decode, input handshake and next state
  always_comb begin
    state_n       = state;
    in_ring_ready = 1'b0;
    to_loc        = 1'b0;
    to_ring       = 1'b0;
    if (alive && in_ring_valid) begin
      unique case (state)
        IDLE: begin
          if (!in_ring_first) begin
            in_ring_ready = 1'b1;
          end else if (hit_bcast) begin
            to_loc        = 1'b1;
            to_ring       = 1'b1;
            in_ring_ready = loc_acc && ring_acc;
            if (in_ring_ready && !in_ring_last)
              state_n = BST;
          end else if (in_ring_data == ID) begin
            to_loc        = 1'b1;
            in_ring_ready = loc_acc;
            if (in_ring_ready && !in_ring_last)
              state_n = WORM_LOCAL;
          end else begin
            to_ring       = 1'b1;
            in_ring_ready = ring_acc;
            if (in_ring_ready && !in_ring_last)
              state_n = WORM_RING;
          end
        end
        WORM_LOCAL: begin
          to_loc        = 1'b1;
          in_ring_ready = loc_acc;
          if (in_ring_ready && in_ring_last)
            state_n = IDLE;
        end
        WORM_RING: begin
          to_ring       = 1'b1;
          in_ring_ready = ring_acc;
          if (in_ring_ready && in_ring_last)
            state_n = IDLE;
        end
`ifdef RING_ROUTER_DEMUX_BCAST_EN
        WORM_BCAST: begin
          to_loc        = 1'b1;
          to_ring       = 1'b1;
          in_ring_ready = loc_acc && ring_acc;
          if (in_ring_ready && in_ring_last)
            state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  // Local output register: load on routed accept, empty on drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_local_valid <= 1'b0;
      out_local_data  <= '0;
      out_local_first <= 1'b0;
      out_local_last  <= 1'b0;
    end else if (fire && to_loc) begin
      out_local_valid <= 1'b1;
      out_local_data  <= in_ring_data;
      out_local_first <= in_ring_first;
      out_local_last  <= in_ring_last;
    end else if (out_local_ready) begin
      out_local_valid <= 1'b0;
    end
  end

  // Ring output register: load on routed accept, empty on drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_ring_valid <= 1'b0;
      out_ring_data  <= '0;
      out_ring_first <= 1'b0;
      out_ring_last  <= 1'b0;
    end else if (fire && to_ring) begin
      out_ring_valid <= 1'b1;
      out_ring_data  <= in_ring_data;
      out_ring_first <= in_ring_first;
      out_ring_last  <= in_ring_last;
    end else if (out_ring_ready) begin
      out_ring_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_router_demux.sv
// Directed bench for ring_router_demux with ID=5.
// Broadcast step runs only when RING_ROUTER_DEMUX_BCAST_EN is defined.
module tb_ring_router_demux;

  logic        clk;
  logic        rst;
  logic [15:0] in_ring_data;
  logic        in_ring_first;
  logic        in_ring_last;
  logic        in_ring_valid;
  logic        in_ring_ready;
  logic [15:0] out_local_data;
  logic        out_local_first;
  logic        out_local_last;
  logic        out_local_valid;
  logic        out_local_ready;
  logic [15:0] out_ring_data;
  logic        out_ring_first;
  logic        out_ring_last;
  logic        out_ring_valid;
  logic        out_ring_ready;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  ring_router_demux #(.ID(16'h0005), .BCAST_ADDR(16'hFFFF)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_ring_data    (in_ring_data),
    .in_ring_first   (in_ring_first),
    .in_ring_last    (in_ring_last),
    .in_ring_valid   (in_ring_valid),
    .in_ring_ready   (in_ring_ready),
    .out_local_data  (out_local_data),
    .out_local_first (out_local_first),
    .out_local_last  (out_local_last),
    .out_local_valid (out_local_valid),
    .out_local_ready (out_local_ready),
    .out_ring_data   (out_ring_data),
    .out_ring_first  (out_ring_first),
    .out_ring_last   (out_ring_last),
    .out_ring_valid  (out_ring_valid),
    .out_ring_ready  (out_ring_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loc_is(input string tag, input logic v, input logic f,
                        input logic l, input logic [15:0] d);
    if (v)
      chk(tag, {13'b0, out_local_valid, out_local_first,
                out_local_last, out_local_data},
          {13'b0, v, f, l, d});
    else
      chk(tag, {31'b0, out_local_valid}, 32'd0);
  endtask

  task automatic ring_is(input string tag, input logic v, input logic f,
                         input logic l, input logic [15:0] d);
    if (v)
      chk(tag, {13'b0, out_ring_valid, out_ring_first,
                out_ring_last, out_ring_data},
          {13'b0, v, f, l, d});
    else
      chk(tag, {31'b0, out_ring_valid}, 32'd0);
  endtask

  task automatic rdy_is(input string tag, input logic e);
    chk(tag, {31'b0, in_ring_ready}, {31'b0, e});
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [15:0] d);
    in_ring_valid = v;
    in_ring_first = f;
    in_ring_last  = l;
    in_ring_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    out_local_ready = 1'b1;
    out_ring_ready  = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0005);
    #3;
    rdy_is("rst_ready", 1'b0);
    loc_is("rst_lv", 1'b0, 1'b0, 1'b0, 16'h0);
    ring_is("rst_rv", 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) tick();
    rdy_is("rst_ready_held", 1'b0);
    rst = 1'b1;
    #1;
    rdy_is("ready_before_edge", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();

    // three-flit worm to local
    drive(1'b1, 1'b1, 1'b0, 16'h0005);
    #1 rdy_is("w3_rdy0", 1'b1);
    tick();
    loc_is("w3_f0", 1'b1, 1'b1, 1'b0, 16'h0005);
    ring_is("w3_r0", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'hAAAA);
    #1 rdy_is("w3_rdy1", 1'b1);
    tick();
    loc_is("w3_f1", 1'b1, 1'b0, 1'b0, 16'hAAAA);
    drive(1'b1, 1'b0, 1'b1, 16'hBBBB);
    tick();
    loc_is("w3_f2", 1'b1, 1'b0, 1'b1, 16'hBBBB);
    ring_is("w3_r2", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    loc_is("w3_done", 1'b0, 1'b0, 1'b0, 16'h0);

    // single flit onward, then worm local
    drive(1'b1, 1'b1, 1'b1, 16'h0009);
    tick();
    ring_is("s9_ring", 1'b1, 1'b1, 1'b1, 16'h0009);
    loc_is("s9_loc", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0005);
    tick();
    loc_is("s9_w0", 1'b1, 1'b1, 1'b0, 16'h0005);
    ring_is("s9_rdrain", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h1234);
    tick();
    loc_is("s9_w1", 1'b1, 1'b0, 1'b1, 16'h1234);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();

    // local sink stalls four cycles
    out_local_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0005);
    tick();
    loc_is("st_f0", 1'b1, 1'b1, 1'b0, 16'h0005);
    drive(1'b1, 1'b0, 1'b0, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      #1;
      rdy_is("st_rdy", 1'b0);
      loc_is("st_hold", 1'b1, 1'b1, 1'b0, 16'h0005);
      tick();
    end
    out_local_ready = 1'b1;
    #1 rdy_is("st_resume", 1'b1);
    tick();
    loc_is("st_f1", 1'b1, 1'b0, 1'b0, 16'h2222);
    drive(1'b1, 1'b0, 1'b1, 16'h3333);
    tick();
    loc_is("st_f2", 1'b1, 1'b0, 1'b1, 16'h3333);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    loc_is("st_done", 1'b0, 1'b0, 1'b0, 16'h0);

    // stray non-first flit in IDLE
    drive(1'b1, 1'b0, 1'b0, 16'h0005);
    #1 rdy_is("stray_rdy", 1'b1);
    tick();
    loc_is("stray_lv", 1'b0, 1'b0, 1'b0, 16'h0);
    ring_is("stray_rv", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 16'h0007);
    tick();
    ring_is("stray_next", 1'b1, 1'b1, 1'b1, 16'h0007);
    loc_is("stray_nl", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();

    // stalled ring output does not block local
    out_ring_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 16'h0009);
    tick();
    ring_is("iso_r", 1'b1, 1'b1, 1'b1, 16'h0009);
    drive(1'b1, 1'b1, 1'b1, 16'h0005);
    #1 rdy_is("iso_rdy", 1'b1);
    tick();
    loc_is("iso_l", 1'b1, 1'b1, 1'b1, 16'h0005);
    ring_is("iso_rh", 1'b1, 1'b1, 1'b1, 16'h0009);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    loc_is("iso_ldrain", 1'b0, 1'b0, 1'b0, 16'h0);
    ring_is("iso_rh2", 1'b1, 1'b1, 1'b1, 16'h0009);
    drive(1'b1, 1'b1, 1'b1, 16'h0008);
    #1 rdy_is("iso_rblk", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    out_ring_ready = 1'b1;
    tick();
    ring_is("iso_rdrain", 1'b0, 1'b0, 1'b0, 16'h0);

    // reset mid-worm
    drive(1'b1, 1'b1, 1'b0, 16'h0009);
    tick();
    ring_is("mr_f0", 1'b1, 1'b1, 1'b0, 16'h0009);
    out_ring_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    #2 rst = 1'b0;
    #1;
    ring_is("mr_rv", 1'b0, 1'b0, 1'b0, 16'h0);
    loc_is("mr_lv", 1'b0, 1'b0, 1'b0, 16'h0);
    rdy_is("mr_rdy", 1'b0);
    rst = 1'b1;
    tick();
    out_ring_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0002);
    #1 rdy_is("mr_disc_rdy", 1'b1);
    tick();
    ring_is("mr_d1r", 1'b0, 1'b0, 1'b0, 16'h0);
    loc_is("mr_d1l", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0003);
    tick();
    ring_is("mr_d2r", 1'b0, 1'b0, 1'b0, 16'h0);
    loc_is("mr_d2l", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 16'h0005);
    tick();
    loc_is("mr_next", 1'b1, 1'b1, 1'b1, 16'h0005);
    ring_is("mr_nr", 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();

`ifdef RING_ROUTER_DEMUX_BCAST_EN
    // broadcast worm with ring sink stalled
    out_ring_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'hFFFF);
    #1 rdy_is("bc_rdy0", 1'b1);
    tick();
    loc_is("bc_l0", 1'b1, 1'b1, 1'b0, 16'hFFFF);
    ring_is("bc_r0", 1'b1, 1'b1, 1'b0, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b1, 16'hCCCC);
    #1 rdy_is("bc_stall_a", 1'b0);
    tick();
    rdy_is("bc_stall_b", 1'b0);
    loc_is("bc_ldrain", 1'b0, 1'b0, 1'b0, 16'h0);
    ring_is("bc_rhold", 1'b1, 1'b1, 1'b0, 16'hFFFF);
    out_ring_ready = 1'b1;
    #1 rdy_is("bc_go", 1'b1);
    tick();
    loc_is("bc_l1", 1'b1, 1'b0, 1'b1, 16'hCCCC);
    ring_is("bc_r1", 1'b1, 1'b0, 1'b1, 16'hCCCC);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
